// File: rtl/delay_tap_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delay_tap_if : sample strobe / tap / delayed output bundle for delay_tap |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface delay_tap_if #(
   parameter int WIDTH = 12,
   parameter int LEN   = 2048
);
   localparam int ADDR = $clog2(LEN);

   logic             sample_en;
   logic [WIDTH-1:0] in;
   logic [ADDR-1:0]  delay;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             overrun;

   modport master (output sample_en, in, delay, input out, out_valid, overrun);
   modport slave  (input sample_en, in, delay, output out, out_valid, overrun);
endinterface
`default_nettype wire

// File: rtl/delay_tap.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | delay_tap : circular-buffer delay line on one inferred RAM, 3-cycle tap  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module delay_tap #(
   parameter  int WIDTH = 12,
   parameter  int LEN   = 2048,
   localparam int ADDR  = $clog2(LEN)
) (
   input  logic        clk,
   input  logic        reset,
   delay_tap_if.slave  bus
);
   localparam logic [1:0]    c_idle = 2'd0;
   localparam logic [1:0]    c_rd   = 2'd1;
   localparam logic [1:0]    c_wr   = 2'd2;
   localparam logic [ADDR:0] c_full = {1'b1, {ADDR{1'b0}}};

   logic [1:0]       r_state;
   logic [ADDR-1:0]  r_wr_ptr;
   logic [ADDR:0]    r_fill;
   logic [ADDR-1:0]  r_rd_addr;
   logic [ADDR-1:0]  r_delay;
   logic [WIDTH-1:0] r_in;
   logic [WIDTH-1:0] r_rd_data;
   logic [WIDTH-1:0] r_out;
   logic             r_out_valid;
   logic             r_overrun;
   logic [WIDTH-1:0] mem [LEN];

   logic             w_mem_we;

   // Reset is gated in so an aborted WR never commits a sample.
   assign w_mem_we = (r_state == c_wr) && !reset;

   always_ff @(posedge clk) begin
      if (w_mem_we)
         mem[r_wr_ptr] <= r_in;
      if (r_state == c_rd)
         r_rd_data <= mem[r_rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= c_idle;
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_rd_addr   <= '0;
         r_delay     <= '0;
         r_in        <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (bus.sample_en && (r_state != c_idle))
            r_overrun <= 1'b1;
         case (r_state)
            c_idle: begin
               if (bus.sample_en) begin
                  r_in      <= bus.in;
                  r_delay   <= bus.delay;
                  r_rd_addr <= r_wr_ptr - bus.delay;
                  r_state   <= c_rd;
               end
            end
            c_rd: begin
               r_state <= c_wr;
            end
            c_wr: begin
               // Zero delay taps the sample being written, not yet in RAM.
               if (r_delay == '0)
                  r_out <= r_in;
               else if (r_fill < {1'b0, r_delay})
                  r_out <= '0;
               else
                  r_out <= r_rd_data;
               r_out_valid <= 1'b1;
               r_wr_ptr    <= r_wr_ptr + ADDR'(1);
               if (r_fill != c_full)
                  r_fill <= r_fill + (ADDR+1)'(1);
               r_state <= c_idle;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_delay_tap.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_delay_tap : directed vector bench for delay_tap (LEN 2048 and LEN 8)  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_delay_tap;
   logic clk;
   logic rst;

   delay_tap_if #(.WIDTH(12), .LEN(2048)) ba ();
   delay_tap_if #(.WIDTH(12), .LEN(8))    b8 ();

   delay_tap #(.WIDTH(12), .LEN(2048)) u_big   (.clk(clk), .reset(rst), .bus(ba));
   delay_tap #(.WIDTH(12), .LEN(8))    u_small (.clk(clk), .reset(rst), .bus(b8));

   typedef struct {
      int          sel;
      logic [11:0] din;
      logic [10:0] dly;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [11:0] get_out(input int sel);
      return (sel == 0) ? ba.out : b8.out;
   endfunction

   function automatic logic get_vld(input int sel);
      return (sel == 0) ? ba.out_valid : b8.out_valid;
   endfunction

   function automatic logic get_ovr(input int sel);
      return (sel == 0) ? ba.overrun : b8.overrun;
   endfunction

   task automatic drive(input int sel, input logic [11:0] din, input logic [10:0] dly);
      logic [10:0] d;
      d = dly;
      if (sel == 0) begin
         ba.sample_en = 1'b1;
         ba.in        = din;
         ba.delay     = d;
      end else begin
         b8.sample_en = 1'b1;
         b8.in        = din;
         b8.delay     = d[2:0];
      end
   endtask

   task automatic release_en();
      ba.sample_en = 1'b0;
      b8.sample_en = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      release_en();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One strobe with 6-cycle spacing; out_valid must rise exactly 3 cycles later.
   task automatic run_strobe(input int sel, input logic [11:0] din, input logic [10:0] dly,
                             input logic [11:0] exp, input string nm);
      @(negedge clk); drive(sel, din, dly);
      @(negedge clk); release_en(); chk({nm, "_vld_c1"}, 32'(get_vld(sel)), 0);
      @(negedge clk); chk({nm, "_vld_c2"}, 32'(get_vld(sel)), 0);
      @(negedge clk); chk({nm, "_vld_c3"}, 32'(get_vld(sel)), 1);
                      chk({nm, "_out"}, 32'(get_out(sel)), 32'(exp));
      @(negedge clk); chk({nm, "_vld_c4"}, 32'(get_vld(sel)), 0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      release_en();
      ba.in = '0; ba.delay = '0;
      b8.in = '0; b8.delay = '0;

      // delay 3 ramp, then zero-delay bypass of both sign extremes
      for (int i = 0; i < 8; i++)
         tbl.push_back('{0, 12'(i + 1), 11'd3, (i < 3) ? 12'd0 : 12'(i - 2)});
      tbl.push_back('{0, 12'h7FF, 11'd0, 12'h7FF});
      tbl.push_back('{0, 12'h800, 11'd0, 12'h800});
      // LEN 8 wrap: tap of 7 returns index-7 once 7 samples exist
      for (int i = 0; i < 20; i++)
         tbl.push_back('{1, 12'(i), 11'd7, (i < 7) ? 12'd0 : 12'(i - 7)});

      repeat (2) @(negedge clk);
      chk("rst_big_out", 32'(ba.out), 0);
      chk("rst_big_vld", 32'(ba.out_valid), 0);
      chk("rst_big_ovr", 32'(ba.overrun), 0);
      rst = 1'b0;
      chk("rst_small_out", 32'(b8.out), 0);
      chk("rst_small_vld", 32'(b8.out_valid), 0);
      chk("rst_small_ovr", 32'(b8.overrun), 0);

      foreach (tbl[k])
         run_strobe(tbl[k].sel, tbl[k].din, tbl[k].dly, tbl[k].exp, $sformatf("vec%0d", k));
      chk("small_ovr_clear", 32'(b8.overrun), 0);

      // Two-cycle spacing: second strobe dropped, overrun sticky
      pulse_reset();
      @(negedge clk); drive(0, 12'h011, 11'd0);
      @(negedge clk); release_en();
      @(negedge clk); drive(0, 12'h022, 11'd0);
      @(negedge clk); release_en();
      chk("ovr_set", 32'(ba.overrun), 1);
      chk("ovr_first_vld", 32'(ba.out_valid), 1);
      chk("ovr_first_out", 32'(ba.out), 32'h011);
      @(negedge clk); chk("ovr_vld_n4", 32'(ba.out_valid), 0);
      @(negedge clk); chk("ovr_vld_n5", 32'(ba.out_valid), 0);
      @(negedge clk); chk("ovr_vld_n6", 32'(ba.out_valid), 0);
      run_strobe(0, 12'h033, 11'd1, 12'h011, "ovr_next");
      chk("ovr_hold", 32'(ba.overrun), 1);

      // Three-cycle spacing: both strobes accepted
      @(negedge clk); drive(0, 12'h044, 11'd1);
      @(negedge clk); release_en();
      @(negedge clk);
      @(negedge clk); drive(0, 12'h055, 11'd1);
      chk("sp3_a_vld", 32'(ba.out_valid), 1);
      chk("sp3_a_out", 32'(ba.out), 32'h033);
      @(negedge clk); release_en(); chk("sp3_gap1", 32'(ba.out_valid), 0);
      @(negedge clk); chk("sp3_gap2", 32'(ba.out_valid), 0);
      @(negedge clk); chk("sp3_b_vld", 32'(ba.out_valid), 1);
      chk("sp3_b_out", 32'(ba.out), 32'h044);

      // Delay 2 -> 5 once four samples are stored
      pulse_reset();
      run_strobe(0, 12'd1, 11'd2, 12'd0, "dc0");
      run_strobe(0, 12'd2, 11'd2, 12'd0, "dc1");
      run_strobe(0, 12'd3, 11'd2, 12'd1, "dc2");
      run_strobe(0, 12'd4, 11'd2, 12'd2, "dc3");
      run_strobe(0, 12'd5, 11'd5, 12'd0, "dc4");
      run_strobe(0, 12'd6, 11'd5, 12'd1, "dc5");
      run_strobe(0, 12'd7, 11'd5, 12'd2, "dc6");

      // Reset while RD is in flight aborts the pending output
      @(negedge clk); drive(0, 12'h0AA, 11'd0);
      @(negedge clk); release_en(); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("rrd_out", 32'(ba.out), 0);
      chk("rrd_vld", 32'(ba.out_valid), 0);
      chk("rrd_ovr", 32'(ba.overrun), 0);
      @(negedge clk); chk("rrd_vld_n3", 32'(ba.out_valid), 0);
      @(negedge clk); chk("rrd_vld_n4", 32'(ba.out_valid), 0);
      run_strobe(0, 12'h066, 11'd1, 12'd0, "rrd_post");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
